// File: rtl/pwm_peripheral.sv
// PWM output stage: 16 pins, each off, static-on or driven by a shared-duty PWM.
// Duty is shadowed and only updated at period boundaries so pin waveforms never glitch.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PrescW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PrescW-1:0] presc_q, presc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        shadow_q, shadow_d;
  logic [15:0]       out_q, out_d;
  logic              wrap_q;
  logic              period_start_q;

  logic        tick;
  logic        wrap;
  logic        pwm;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick     = (presc_q == PrescW'(CLK_DIV - 1));
    wrap     = tick && (cnt_q == 8'hFF);
    presc_d  = tick ? '0 : presc_q + PrescW'(1);
    cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
    // Loading on the wrap edge makes the new duty apply from cnt=0 of the next period.
    shadow_d = wrap ? pwm_duty_cycle : shadow_q;
  end

  always_comb begin
    pwm = (shadow_q == 8'hFF) ? 1'b1 : (cnt_q < shadow_q);
    for (int i = 0; i < 16; i++) begin
      out_d[i] = en_out[i] ? (en_pwm[i] ? pwm : 1'b1) : 1'b0;
    end
  end

  // period_start is delayed twice so it lines up with the first registered out of the period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= 8'h00;
      shadow_q       <= 8'h00;
      out_q          <= 16'h0000;
      wrap_q         <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      out_q          <= out_d;
      wrap_q         <= wrap;
      period_start_q <= wrap_q;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral with CLK_DIV=4: expected per-cycle pin values are queued up front,
// a negedge monitor pops and compares the entry tagged with the current cycle.
module tb_pwm_peripheral;

  localparam int unsigned ClkDiv = 4;
  localparam int LastCyc = 8345;

  typedef struct {
    int          cyc;
    logic [15:0] out;
    logic        ps;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  pwm_peripheral #(
    .CLK_DIV(ClkDiv)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .out            (out),
    .period_start   (period_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of posedges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // Queue expectations for cycles start..start+len-1; only the first may carry period_start.
  function automatic void span(input int start, input int len, input logic [15:0] o,
                               input logic first_ps);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.cyc = start + i;
      e.out = o;
      e.ps  = (i == 0) ? first_ps : 1'b0;
      sb.push_back(e);
    end
  endfunction

  // Return at the negedge just before posedge number k.
  task automatic go_to(input int k);
    while (cyc < k - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      failures++;
      $display("FAIL missed cyc=%0d expectation, now cyc=%0d", sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (out !== e.out || period_start !== e.ps) begin
        failures++;
        $display("FAIL pins cyc=%0d out=%h period_start=%b required out=%h period_start=%b",
                 cyc, out, period_start, e.out, e.ps);
      end
    end
    if (cyc == LastCyc + 1) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL drain leftover=%0d required 0", sb.size());
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    en_reg_out_7_0  = 8'hFF;
    en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0  = 8'hFF;
    en_reg_pwm_15_8 = 8'hFF;
    pwm_duty_cycle  = 8'hFF;

    // Timeline: first edge after reset release is 4, so periods start at 1028 + 1024*n.
    span(1,    4,    16'h0000, 1'b0);  // reset held, then first free edge
    span(5,    16,   16'h0001, 1'b0);  // static pin 0
    span(21,   1007, 16'h0000, 1'b0);  // PWM enabled but shadow still 0
    span(1028, 512,  16'hFFFF, 1'b1);  // duty 0x80
    span(1540, 512,  16'h0000, 1'b0);
    span(2052, 148,  16'h0000, 1'b1);  // duty 0x00
    span(2200, 300,  16'h03C0, 1'b0);  // mixed enables, pwm low
    span(2500, 576,  16'h0000, 1'b0);
    span(3076, 1024, 16'hFFFF, 1'b1);  // duty 0xFF, no low at cnt=255
    span(4100, 256,  16'hFFFF, 1'b1);  // duty 0x40 captured on wrap edge
    span(4356, 768,  16'h0000, 1'b0);
    span(5124, 768,  16'hFFFF, 1'b1);  // duty 0xC0
    span(5892, 256,  16'h0000, 1'b0);
    span(6148, 148,  16'hFFFF, 1'b1);  // duty 0x80, reset at cnt=37
    span(6296, 1026, 16'h0000, 1'b0);  // reset and first period with shadow 0
    span(7322, 512,  16'hFFFF, 1'b1);
    span(7834, 512,  16'h0000, 1'b0);

    go_to(4);
    rst_n = 1'b1;
    go_to(5);
    {en_reg_out_15_8, en_reg_out_7_0} = 16'h0001;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'h0000;
    pwm_duty_cycle = 8'h00;
    go_to(21);
    {en_reg_out_15_8, en_reg_out_7_0} = 16'hFFFF;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'hFFFF;
    pwm_duty_cycle = 8'h80;
    go_to(1500);
    pwm_duty_cycle = 8'h00;
    go_to(2200);
    {en_reg_out_15_8, en_reg_out_7_0} = 16'h0FF0;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'h3C3C;
    go_to(2500);
    {en_reg_out_15_8, en_reg_out_7_0} = 16'hFFFF;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'hFFFF;
    go_to(2600);
    pwm_duty_cycle = 8'hFF;
    go_to(4099);
    pwm_duty_cycle = 8'h40;
    go_to(4200);
    pwm_duty_cycle = 8'hC0;
    go_to(5500);
    pwm_duty_cycle = 8'h80;
    go_to(6296);
    rst_n = 1'b0;
    go_to(6298);
    rst_n = 1'b1;
    go_to(LastCyc + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
